// File: rtl/vx_commit_arb_if.sv
// Handshake bundle between the execute units and the writeback arbiter.
// master = execute/issue side, slave = the arbiter itself.
interface vx_commit_arb_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]       in_valid;
  logic [NUM_REQS*DATAW-1:0] in_data;
  logic [NUM_REQS-1:0]       in_eop;
  logic [NUM_REQS-1:0]       in_ready;
  logic                      out_valid;
  logic [DATAW-1:0]          out_data;
  logic                      out_eop;
  logic [SELW-1:0]           out_sel;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_eop, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_eop, out_sel
  );
endinterface

// File: rtl/vx_commit_arb.sv
// Round-robin writeback arbiter with packet lock and a 2-entry output buffer.
// Optional stall counter enabled by defining VX_COMMIT_ARB_PERF_EN.
module vx_commit_arb #(
  parameter int NUM_REQS      = 4,
  parameter int DATAW         = 64,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_commit_arb_if.slave           bus,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
);
  localparam int SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_reg;
  logic [SELW-1:0]     rr_ptr_reg;
  logic [SELW-1:0]     lock_sel_reg;
  logic [1:0]          count_reg;
  logic                rd_ptr_reg;
  logic                wr_ptr_reg;
  logic [DATAW-1:0]    buf_data_reg [2];
  logic                buf_eop_reg  [2];
  logic [SELW-1:0]     buf_sel_reg  [2];

  logic [NUM_REQS-1:0] grant;
  logic [SELW-1:0]     win_sel;
  logic [SELW-1:0]     rr_ptr_next;
  logic [DATAW-1:0]    win_data;
  logic                win_eop;
  logic                push;
  logic                pop;
  logic                found;
  int                  idx;

  // While locked only the owner may be granted; otherwise scan upward from rr_ptr.
  always_comb begin
    grant   = '0;
    win_sel = rr_ptr_reg;
    found   = 1'b0;
    idx     = 0;
    if (state_reg == LOCKED) begin
      grant[lock_sel_reg] = bus.in_valid[lock_sel_reg];
      win_sel             = lock_sel_reg;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_REQS;
        if (!found && bus.in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          win_sel    = SELW'(idx);
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
    assign bus.in_ready[gi] = grant[gi] && (count_reg < 2'd2) && !reset;
  end

  assign push        = |(bus.in_valid & bus.in_ready);
  assign pop         = (count_reg != 2'd0) && bus.out_ready;
  assign win_data    = bus.in_data[win_sel*DATAW +: DATAW];
  assign win_eop     = bus.in_eop[win_sel];
  assign rr_ptr_next = (win_sel == SELW'(NUM_REQS-1)) ? '0 : win_sel + 1'b1;

  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_data  = buf_data_reg[rd_ptr_reg];
  assign bus.out_eop   = buf_eop_reg[rd_ptr_reg];
  assign bus.out_sel   = buf_sel_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      lock_sel_reg <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        buf_data_reg[e] <= '0;
        buf_eop_reg[e]  <= 1'b0;
        buf_sel_reg[e]  <= '0;
      end
    end else begin
      if (push) begin
        buf_data_reg[wr_ptr_reg] <= win_data;
        buf_eop_reg[wr_ptr_reg]  <= win_eop;
        buf_sel_reg[wr_ptr_reg]  <= win_sel;
        wr_ptr_reg               <= ~wr_ptr_reg;
        // Pointer only advances when a packet completes, so a multi-beat packet keeps priority.
        if (win_eop) begin
          rr_ptr_reg <= rr_ptr_next;
          state_reg  <= IDLE;
        end else begin
          state_reg    <= LOCKED;
          lock_sel_reg <= win_sel;
        end
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef VX_COMMIT_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reg <= '0;
    end else if ((|bus.in_valid) && !push) begin
      perf_reg <= perf_reg + 1'b1;
    end
  end

  assign perf_stalls = perf_reg;
`else
  assign perf_stalls = '0;
`endif
endmodule

// File: doc/vx_commit_arb.md
# vx_commit_arb

Per-issue-slot writeback arbiter between the execute units (ALU, LSU, FPU, SFU) and the issue stage. It merges the result streams of NUM_REQS units into one writeback stream. That stream feeds the issue stage's writeback port, which the scoreboard and operand register file consume. The block uses round-robin arbitration, holds a grant across multi-beat packets until the end-of-packet beat, and registers its output through a 2-entry elastic buffer.

## Interface

Parameters:
- NUM_REQS, 4: number of execute-unit inputs (≥2).
- DATAW, 64: payload width per beat (uuid/wid/PC/tmask/rd/data packed by caller).
- PERF_CTR_BITS, 44: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQS  per-unit beat valid.
- in_data  in  NUM_REQS*DATAW  per-unit payload; unit i occupies bits [i*DATAW +: DATAW].
- in_eop  in  NUM_REQS  per-unit end-of-packet flag for the current beat.
- in_ready  out  NUM_REQS  per-unit accept; one-hot or zero.
- out_valid  out  1  writeback beat valid.
- out_data  out  DATAW  writeback payload.
- out_eop  out  1  end-of-packet of the output beat.
- out_sel  out  max(1,$clog2(NUM_REQS))  index of the unit that produced the output beat.
- out_ready  in  1  downstream accept.
- perf_stalls  out  PERF_CTR_BITS  stall-cycle counter; see Configuration.

## Operation

- Input transfer: in_valid[i] && in_ready[i].
- Output transfer: out_valid && out_ready.
- Arbiter FSM:
  - IDLE: the grant goes to the first valid input scanning from pointer rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQS-1, 0, …).
  - IDLE → LOCKED(w): a transfer from winner w with in_eop=0. Only w is eligible while LOCKED.
  - LOCKED(w) → IDLE: the transfer of w's beat with in_eop=1.
  - Single-beat packets (in_eop=1) never leave IDLE.
- rr_ptr updates to (winner+1) mod NUM_REQS on every transfer with in_eop=1, and only then. It is unchanged on non-eop beats and on cycles with no transfer.
- in_ready[i] = grant[i] && (count < 2) && !reset. It must not depend combinationally on out_ready.
- Buffer: 2-entry FIFO holding {data, eop, sel}, with count 0..2.
  - out_valid = (count != 0); out_data, out_eop and out_sel come from the head entry.
  - Push and pop in the same cycle leave count unchanged. Order is preserved.
- Packet integrity: no beat of another unit appears on the output between a unit's first beat and its eop beat.
- A LOCKED unit that drops in_valid mid-packet stalls the arbiter; other units wait, and no timeout applies.
- in_data of non-granted units is ignored.

## Timing

- Reset values: out_valid=0, out_data=0, out_eop=0, out_sel=0, in_ready=0, perf_stalls=0, count=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-packet discards the buffer contents and lock state. Behaviour after reset is identical to power-up.
- Latency: an accepted input beat is visible on out_* on the next cycle, provided the buffer was empty.
- Throughput: one beat per cycle sustained while out_ready=1 (steady state count=1).
- Backpressure: with out_ready=0, at most 2 beats are absorbed. in_ready then drops the cycle after count reaches 2.
- When the buffer is full and out_ready=1, the pop occurs but no push happens that cycle. in_ready rises on the next cycle.
- rr_ptr and the FSM update in the same edge as the transfer.
- The grant is combinational from the in_valid values of the current cycle.

## Configuration

- Macro: VX_COMMIT_ARB_PERF_EN.
- Defined:
  - perf_stalls increments by 1 each cycle where (|in_valid) && !(|(in_valid & in_ready)), i.e. some unit is waiting and nothing transfers.
  - The counter wraps modulo 2^PERF_CTR_BITS.
- Undefined: the counter logic is removed and perf_stalls is tied to 0. The port remains present.

## Test plan

- Reset then idle: hold reset 3 cycles with in_valid=4'b1111. Required: in_ready=0, out_valid=0, perf_stalls=0 throughout. After deassertion, unit 0 is granted first.
- Round-robin: all 4 units assert single-beat packets continuously with out_ready=1. Required: out_sel sequence 0,1,2,3,0,1…, one beat per cycle after a 1-cycle latency.
- Packet lock: unit 2 sends 3 beats (eop only on the third) while unit 0 is valid. Required: out_sel=2,2,2 then 0; rr_ptr=3 after the eop beat.
- Backpressure: out_ready=0 with unit 1 streaming. Required: exactly 2 beats accepted; in_ready[1]=0 from the cycle after count=2. With out_ready=1, the beats drain in order with data intact.
- Perf counter (VX_COMMIT_ARB_PERF_EN defined): 5 full-buffer stall cycles with in_valid[3]=1. Required: perf_stalls=5. With the macro undefined, perf_stalls stays 0.
- Mid-packet reset: assert reset after 1 of 2 beats from unit 1. Required: out_valid=0 next cycle; afterwards unit 0 wins if valid (rr_ptr=0, state IDLE).
